// File: rtl/fetch_types.sv
// Shared fetch-path types: the packet carried from fetch to decode.
package fetch_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_queue.sv
// Multi-lane fetch queue: up to ENQ_WIDTH packets in and DEQ_WIDTH out per cycle, zero-latency read, no bypass.
// Backpressure: in_ready drops unless ENQ_WIDTH entries are free (registered state only); flush empties the queue.
module fetch_queue
    import fetch_types::*;
#(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    input  logic [$clog2(ENQ_WIDTH+1)-1:0]       in_count,
    input  fetch_packet_t [ENQ_WIDTH-1:0]        in_packet,
    output logic                                 in_ready,
    output logic [DEQ_WIDTH-1:0]                 out_valid,
    output fetch_packet_t [DEQ_WIDTH-1:0]        out_packet,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]       out_count,
    output logic [$clog2(DEPTH+1)-1:0]           occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MAX_W = (ENQ_WIDTH > DEQ_WIDTH) ? ENQ_WIDTH : DEQ_WIDTH;

    localparam logic [PTR_W-1:0] ENQ_MAX   = PTR_W'(ENQ_WIDTH);
    localparam logic [PTR_W-1:0] DEQ_MAX   = PTR_W'(DEQ_WIDTH);
    localparam logic [PTR_W-1:0] OCC_LIMIT = PTR_W'(DEPTH - ENQ_WIDTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * MAX_W) begin : g_bad_depth
        $fatal(1, "fetch_queue: DEPTH must be a power of two and at least 2*max(ENQ_WIDTH, DEQ_WIDTH)");
    end

    fetch_packet_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] occ;
    logic [PTR_W-1:0] enq_n;
    logic [PTR_W-1:0] deq_n;
    logic             enq_fire;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign occ       = wr_ptr - rd_ptr;
    assign occupancy = CNT_W'(occ);
    assign in_ready  = (occ <= OCC_LIMIT);
    assign enq_fire  = in_valid && in_ready && !flush;
    assign wr_idx    = wr_ptr[IDX_W-1:0];
    assign rd_idx    = rd_ptr[IDX_W-1:0];

    // Oversized counts are clamped to the lane width and to what is actually queued.
    always_comb begin
        enq_n = PTR_W'(in_count);
        if (enq_n > ENQ_MAX) enq_n = ENQ_MAX;
        deq_n = PTR_W'(out_count);
        if (deq_n > DEQ_MAX) deq_n = DEQ_MAX;
        if (deq_n > occ)     deq_n = occ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + enq_n;
            rd_ptr <= rd_ptr + deq_n;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (PTR_W'(i) < enq_n) mem[wr_idx + IDX_W'(i)] <= in_packet[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            out_valid[i]  = (occ > PTR_W'(i));
            out_packet[i] = mem[rd_idx + IDX_W'(i)];
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries; power of two, at least 2*max(ENQ_WIDTH, DEQ_WIDTH).
REQ-002 SHALL have parameter ENQ_WIDTH, default 4, maximum packets enqueued per cycle.
REQ-003 SHALL have parameter DEQ_WIDTH, default 2, maximum packets dequeued per cycle.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  discard all queued packets (branch redirect).
REQ-007 in_valid  input  1  enqueue request this cycle.
REQ-008 in_count  input  $clog2(ENQ_WIDTH+1)  number of valid lanes; lanes 0..in_count-1 are valid.
REQ-009 in_packet  input  ENQ_WIDTH x fetch_packet_t  enqueue lanes, lane 0 oldest.
REQ-010 in_ready  output  1  space for ENQ_WIDTH packets exists.
REQ-011 out_valid  output  DEQ_WIDTH  per-lane valid, thermometer-coded from lane 0.
REQ-012 out_packet  output  DEQ_WIDTH x fetch_packet_t  oldest packets, lane 0 = head.
REQ-013 out_count  input  $clog2(DEQ_WIDTH+1)  packets the consumer takes this cycle, from lane 0.
REQ-014 occupancy  output  $clog2(DEPTH+1)  current entry count.

Function
REQ-015 Pointers SHALL be $clog2(DEPTH)+1 bits (wrap flag + index); the index SHALL wrap modulo DEPTH.
REQ-016 occupancy SHALL equal wr_ptr - rd_ptr, truncated to pointer width; empty at 0, full at DEPTH.
REQ-017 in_ready SHALL be 1 iff DEPTH - occupancy >= ENQ_WIDTH, from registered state only; same-cycle dequeues do not count toward it.
REQ-018 Enqueue fires iff in_valid && in_ready && !flush: lane i is written to entry (wr_ptr+i) mod DEPTH for i < in_count, and wr_ptr advances by in_count.
REQ-019 in_valid with in_count=0 SHALL change nothing.
REQ-020 out_valid[i] SHALL be 1 iff occupancy > i; out_packet[i] SHALL be entry (rd_ptr+i) mod DEPTH; invalid lanes are don't-care.
REQ-021 Dequeue SHALL advance rd_ptr by min(out_count, occupancy, DEQ_WIDTH) when !flush; excess out_count is ignored.
REQ-022 Enqueue and dequeue in the same cycle SHALL both take effect; occupancy becomes old + enq - deq.
REQ-023 Read latency SHALL be zero: an entry written at edge N is visible on out_packet after edge N, and never on the same cycle as its enqueue (no bypass).
REQ-024 flush SHALL have priority: at the next edge rd_ptr <= wr_ptr, and same-cycle enqueue and dequeue are discarded.
REQ-025 After flush, out_valid = 0, occupancy = 0, and in_ready = 1 on the following cycle.

Reset
REQ-026 Asserting rst_n low SHALL immediately and asynchronously clear wr_ptr and rd_ptr to 0, giving out_valid=0, occupancy=0 and in_ready=1.
REQ-027 Storage entries SHALL NOT be reset.
REQ-028 Reset asserted mid-operation SHALL drop all entries with no partial commit.
REQ-029 Release of rst_n SHALL be synchronous to clk; the first enqueue is accepted on the first edge after release.

Structure
REQ-030 fetch_packet_t SHALL live in the shared fetch_types package; DEPTH, ENQ_WIDTH and DEQ_WIDTH are module parameters and are not package constants.
REQ-031 No sub-module is needed; storage, pointers and lane muxes are inline.
REQ-032 An elaboration-time check SHALL reject DEPTH not a power of two or DEPTH < 2*max(ENQ_WIDTH, DEQ_WIDTH).

Verification (DEPTH=8, ENQ_WIDTH=4, DEQ_WIDTH=2)
REQ-033 Reset, then enqueue 4 packets tagged A0..A3 with out_count=0 -> next cycle occupancy=4, out_valid=2'b11, lanes show A0,A1, in_ready=1.
REQ-034 Enqueue 4 more (B0..B3) -> occupancy=8, in_ready=0; an enqueue attempt while in_ready=0 is ignored and occupancy stays 8.
REQ-035 Hold out_count=2 while enqueueing in_count=3 each time in_ready=1 -> continuous stream in order across pointer wrap, no loss or duplicate, occupancy never exceeds 8.
REQ-036 With occupancy=1, out_count=2 -> exactly 1 dequeued, occupancy=0, out_valid=2'b00.
REQ-037 Occupancy=5 with flush, in_valid=1, in_count=4, out_count=2 in the same cycle -> occupancy=0 and out_valid=0 next cycle, and no flushed-cycle packet ever appears.
REQ-038 Drop rst_n asynchronously mid-stream with occupancy=6 -> outputs clear before the next edge; after release, the first enqueued packet appears on lane 0.
